// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor.
//   mode_e   : operation select carried on the m input (ADD / SUB)
//   sat_max  : most positive two's-complement value of a given width
//   sat_min  : most negative two's-complement value of a given width
// Both helpers return a MAX_WIDTH vector; callers cast down to their own width.
package addsub_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } mode_e;

    localparam int unsigned MAX_WIDTH = 64;

    // 0111...1 in the low 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] sat_max(input int unsigned width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int unsigned i = 0; i + 1 < width; i++) begin
            r[i] = 1'b1;
        end
        return r;
    endfunction

    // 1000...0 in the low 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] sat_min(input int unsigned width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        r[width-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// CHUNK-bit ripple-carry adder used as one pipeline stage of addsub_pipe.
// Ports:
//   a, b  : operand slices (b is already inverted for subtraction)
//   cin   : carry into bit 0 of the slice
//   sum   : slice sum
//   cout  : carry out of the slice MSB
//   cmsb  : carry into the slice MSB (needed for signed overflow at the top slice)
module addsub_slice
    import addsub_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[CHUNK];
    assign cmsb = c[CHUNK-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor with valid/ready handshake,
// optional signed saturation and a sticky overflow flag.
// The carry chain is cut into CHUNK-bit slices, one slice resolved per stage,
// so latency is WIDTH/CHUNK cycles at one beat per cycle.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid, in_ready  : input handshake (in_ready depends only on output side)
//   a, b, m, sat        : operands, mode (0 add, 1 subtract), saturate enable
//   out_valid, out_ready: output handshake
//   s, cout, v          : result, carry out of MSB (1 = no borrow on subtract),
//                         unsaturated signed overflow
//   clr_sticky          : clear ovf_sticky
//   ovf_sticky          : set by any delivered beat with v=1 (set beats clear)
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             v,
    input  logic             clr_sticky,
    output logic             ovf_sticky
);

    // WIDTH is expected to be a non-zero multiple of CHUNK.
    localparam int unsigned STAGES = WIDTH / CHUNK;

    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    logic stall;
    logic accept;

    // Global stall: the whole pipe freezes while the output beat is refused.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed when entering stage k.
        localparam int unsigned UP = WIDTH - k * CHUNK;

        logic [UP-1:0]          a_in;
        logic [UP-1:0]          bn_in;
        logic                   cin;
        logic                   vld_in;
        logic                   sat_in;
        logic                   sign_in;
        logic [(k+1)*CHUNK-1:0] sum_d;

        logic [CHUNK-1:0]       slice_sum;
        logic                   slice_cout;
        logic                   slice_cmsb;

        logic                   vld_q;
        logic                   carry_q;
        logic                   sat_q;
        logic                   sign_q;
        logic [(k+1)*CHUNK-1:0] sum_q;

        if (k == 0) begin : g_src
            // B is inverted and carry-in set to the mode so SUB becomes A + ~B + 1.
            assign a_in    = a;
            assign bn_in   = (m == SUB) ? ~b : b;
            assign cin     = (m == SUB);
            assign vld_in  = accept;
            assign sat_in  = sat;
            assign sign_in = a[WIDTH-1];
            assign sum_d   = slice_sum;
        end else begin : g_src
            assign a_in    = g_stage[k-1].g_fwd.a_q;
            assign bn_in   = g_stage[k-1].g_fwd.bn_q;
            assign cin     = g_stage[k-1].carry_q;
            assign vld_in  = g_stage[k-1].vld_q;
            assign sat_in  = g_stage[k-1].sat_q;
            assign sign_in = g_stage[k-1].sign_q;
            // Resolved lower slices ride along so the full sum aligns at the end.
            assign sum_d   = {slice_sum, g_stage[k-1].sum_q};
        end

        addsub_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .a   (a_in[CHUNK-1:0]),
            .b   (bn_in[CHUNK-1:0]),
            .cin (cin),
            .sum (slice_sum),
            .cout(slice_cout),
            .cmsb(slice_cmsb)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q   <= 1'b0;
                carry_q <= 1'b0;
                sat_q   <= 1'b0;
                sign_q  <= 1'b0;
                sum_q   <= '0;
            end else if (!stall) begin
                vld_q   <= vld_in;
                carry_q <= slice_cout;
                sat_q   <= sat_in;
                sign_q  <= sign_in;
                sum_q   <= sum_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Skew registers: upper operand slices still waiting for their stage.
            logic [UP-CHUNK-1:0] a_q;
            logic [UP-CHUNK-1:0] bn_q;
            logic                unused_cmsb;

            assign unused_cmsb = slice_cmsb;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q  <= '0;
                    bn_q <= '0;
                end else if (!stall) begin
                    a_q  <= a_in[UP-1:CHUNK];
                    bn_q <= bn_in[UP-1:CHUNK];
                end
            end
        end else begin : g_last
            logic cmsb_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cmsb_q <= 1'b0;
                end else if (!stall) begin
                    cmsb_q <= slice_cmsb;
                end
            end
        end
    end

    logic                   fin_sat;
    logic                   fin_sign;
    logic [WIDTH-1:0]       fin_sum;
    logic                   fin_cmsb;
    logic                   ovf_sticky_q;
    logic                   ovf_sticky_d;

    assign out_valid = g_stage[STAGES-1].vld_q;
    assign cout      = g_stage[STAGES-1].carry_q;
    assign fin_cmsb  = g_stage[STAGES-1].g_last.cmsb_q;
    assign fin_sat   = g_stage[STAGES-1].sat_q;
    assign fin_sign  = g_stage[STAGES-1].sign_q;
    assign fin_sum   = g_stage[STAGES-1].sum_q;

    // v always reflects the raw sum, even when s is clamped.
    assign v = cout ^ fin_cmsb;

    // Overflow direction follows the sign of A for both add and subtract.
    always_comb begin
        s = fin_sum;
        if (fin_sat && v) begin
            s = fin_sign ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (out_valid && out_ready && v) begin
            ovf_sticky_d = 1'b1;
        end else if (clr_sticky) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_addsub_pipe.sv
module tb_addsub_pipe;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned CHUNK  = 4;
    localparam int unsigned STAGES = WIDTH / CHUNK;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        v;
        int          acc;
        bit          chk;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_m;
    logic        op_sat;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        v;
    logic        clr_sticky;
    logic        ovf_sticky;

    int   total;
    int   bad;
    int   cyc;
    int   n_deliv;
    exp_t sb[$];
    exp_t me;
    exp_t e0;

    logic [15:0] st_a[8];
    logic [15:0] st_b[8];
    logic        st_m[8];
    logic        st_s[8];
    int          d0;

    addsub_pipe #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (op_a),
        .b         (op_b),
        .m         (op_m),
        .sat       (op_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .v         (v),
        .clr_sticky(clr_sticky),
        .ovf_sticky(ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference model: 17-bit arithmetic, overflow from operand/result signs.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mm, input logic ms);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] full;
        bb     = mm ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + {16'b0, mm};
        e.cout = full[16];
        if (mm) e.v = (ma[15] != mb[15]) && (full[15] != ma[15]);
        else    e.v = (ma[15] == mb[15]) && (full[15] != ma[15]);
        e.s    = (ms && e.v) ? (ma[15] ? 16'h8000 : 16'h7FFF) : full[15:0];
        e.acc  = 0;
        e.chk  = 1'b0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for acceptance, push its expectation.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tm,
                        input logic ts, input bit chk);
        exp_t e;
        int   n;
        bit   ok;
        op_a     = ta;
        op_b     = tb;
        op_m     = tm;
        op_sat   = ts;
        in_valid = 1'b1;
        n        = 0;
        ok       = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            n++;
        end
        check("accept", 32'(ok), 32'd1);
        if (ok) begin
            e     = model(ta, tb, tm, ts);
            e.acc = cyc;
            e.chk = chk;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        step();
    endtask

    // Scoreboard consumer: every delivered beat is popped and compared.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_deliv++;
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL spurious: observed=beat s=%0h expected=none", s);
            end
            if (sb.size() != 0) begin
                me = sb.pop_front();
                check("s", 32'(s), 32'(me.s));
                check("cout", 32'(cout), 32'(me.cout));
                check("v", 32'(v), 32'(me.v));
                if (me.chk) check("latency", 32'(cyc - me.acc), STAGES);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total      = 0;
        bad        = 0;
        cyc        = 0;
        n_deliv    = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        op_a       = '0;
        op_b       = '0;
        op_m       = 1'b0;
        op_sat     = 1'b0;
        out_ready  = 1'b1;
        clr_sticky = 1'b0;

        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_v", 32'(v), 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Add overflow, wrapped then saturated.
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain();
        @(negedge clk);
        check("sticky_after_ovf", 32'(ovf_sticky), 32'd1);
        step();
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1);
        drain();

        // Subtract with borrow, signed overflow on subtract, unsigned wrap.
        send(16'h0003, 16'h0005, 1'b1, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
        send(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drain();

        // Clear with no overflow delivery.
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_clr", 32'(ovf_sticky), 32'd0);
        step();

        // Clear asserted across the cycle an overflow beat is delivered: set wins.
        send(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b1);
        step();
        step();
        clr_sticky = 1'b1;
        step();
        step();
        clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_collision", 32'(ovf_sticky), 32'd1);
        step();
        drain();
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_clr2", 32'(ovf_sticky), 32'd0);
        step();

        // Streaming with a 3-cycle stall mid-stream.
        for (int i = 0; i < 8; i++) begin
            st_a[i] = 16'($urandom);
            st_b[i] = 16'($urandom);
            st_m[i] = 1'($urandom);
            st_s[i] = 1'($urandom);
        end
        d0 = n_deliv;
        for (int i = 0; i < 4; i++) send(st_a[i], st_b[i], st_m[i], st_s[i], 1'b0);
        e0        = model(st_a[0], st_b[0], st_m[0], st_s[0]);
        out_ready = 1'b0;
        op_a      = st_a[4];
        op_b      = st_b[4];
        op_m      = st_m[4];
        op_sat    = st_s[4];
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_s", 32'(s), 32'(e0.s));
            check("stall_cout", 32'(cout), 32'(e0.cout));
            check("stall_v", 32'(v), 32'(e0.v));
            step();
        end
        out_ready = 1'b1;
        for (int i = 4; i < 8; i++) send(st_a[i], st_b[i], st_m[i], st_s[i], 1'b0);
        drain();
        check("stream_count", 32'(n_deliv - d0), 32'd8);

        // Reset with beats in flight: nothing emerges, sticky cleared.
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        send(16'h1234, 16'h0101, 1'b0, 1'b0, 1'b0);
        send(16'h0F00, 16'h00F0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        sb.delete();
        d0 = n_deliv;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("flush_out_valid", 32'(out_valid), 32'd0);
            check("flush_sticky", 32'(ovf_sticky), 32'd0);
            step();
        end
        check("flush_count", 32'(n_deliv - d0), 32'd0);
        send(16'h4000, 16'h4000, 1'b0, 1'b1, 1'b1);
        drain();
        check("post_rst_count", 32'(n_deliv - d0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor: WIDTH-bit operands, carry chain split into CHUNK-bit slices, one slice per pipeline stage.
- Adds a valid/ready handshake with backpressure, optional signed saturation, and a sticky overflow status.
- Successor to the 4-bit combinational add/sub unit; used as the arithmetic datapath element in streaming blocks.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK, minimum 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts the beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- m  in  1  0 = A+B, 1 = A-B (A + ~B + 1)
- sat  in  1  1 = saturate the signed result on overflow
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts the result
- s  out  WIDTH  result
- cout  out  1  carry out of the MSB; for subtract, 1 = no borrow
- v  out  1  signed overflow of the unsaturated result
- clr_sticky  in  1  clear the sticky flag
- ovf_sticky  out  1  set by any delivered result with v=1

Behaviour:
- Reset (asynchronous): all stage valid bits=0, out_valid=0, s=0, cout=0, v=0, ovf_sticky=0. Asserting rst mid-operation discards all in-flight beats; no output is produced for them.
- Accept: a beat is accepted when in_valid && in_ready. a, b, m and sat are captured with the beat. B is inverted and carry-in is set to m at capture.
- Stage k (0..STAGES-1) adds slice k of A and B' with the carry from stage k-1, and registers that sum slice. Unresolved upper slices are carried forward in skew registers. Lower result slices are delayed so they align at the output.
- Latency: exactly STAGES cycles from accept to out_valid when there is no stall. Throughput is 1 beat per cycle.
- Final stage:
  - cout = carry out of bit WIDTH-1.
  - v = carry into MSB XOR carry out of MSB.
  - If sat && v: s = A[MSB] ? {1,0...0} : {0,1...1}. Otherwise s = raw sum.
  - v reports the unsaturated overflow even when saturated.
- Backpressure: global stall. stall = out_valid && !out_ready.
  - While stalled, every stage register holds and in_ready=0.
  - in_ready = !stall, purely combinational from out_valid and out_ready; no combinational path from in_valid.
  - Bubbles are not compressed.
- Output rules: out_valid, s, cout and v remain stable while stalled. A beat is delivered on out_valid && out_ready.
- Sticky flag:
  - ovf_sticky sets on any delivered beat with v=1.
  - clr_sticky clears it.
  - If a set and a clear occur in the same cycle, set wins.
- Wrap-around: without sat, results wrap modulo 2^WIDTH.
- STAGES=1 degenerates to a single registered full adder with the same handshake.

Decomposition:
- Shared package addsub_pkg: mode encodings ADD=0 and SUB=1; function for saturation constants sat_max(WIDTH) and sat_min(WIDTH).
- One sub-module, addsub_slice: CHUNK-bit ripple adder (a, b', cin → sum, cout, carry-into-MSB). It is instantiated once per stage by a generate loop.

Test Plan (WIDTH=16, CHUNK=4, latency 4; out_ready=1 unless noted):
- Add overflow: a=0x7FFF, b=0x0001, m=0, sat=0 -> 4 cycles later s=0x8000, cout=0, v=1, ovf_sticky=1 the next cycle. Same with sat=1 -> s=0x7FFF, v=1.
- Subtract with borrow: a=0x0003, b=0x0005, m=1 -> s=0xFFFE, cout=0, v=0. Then a=0x8000, b=0x0001, m=1, sat=1 -> s=0x8000, cout=1, v=1; with sat=0 -> s=0x7FFF.
- Unsigned wrap: a=0xFFFF, b=0x0001, m=0 -> s=0x0000, cout=1, v=0.
- Streaming with stall: 8 random back-to-back beats, out_ready=0 for 3 cycles mid-stream.
  - in_ready must be 0 during the stall, and outputs must hold stable.
  - All 8 results must be delivered in order and match a reference model, with none lost or duplicated.
- Reset mid-flight: accept 3 beats, assert rst for 1 cycle before any output -> out_valid stays 0, ovf_sticky=0, next accepted beat emerges after exactly 4 cycles.
- Sticky collision: deliver a v=1 beat in the same cycle clr_sticky=1 -> ovf_sticky=1. A clr_sticky pulse on a cycle with no v=1 delivery -> ovf_sticky=0.
